// File: rtl/ring_path_arbiter.sv
// ring_path_arbiter: shares one fixed-latency datapath stage among NUM_REQ
// requesters. It uses round-robin arbitration with a burst cap, tags each
// launched beat with its requester ID, and routes the result back PIPE_LAT
// cycles after launch. A RUN/DRAIN/HALT machine quiesces the path on flush_req.
//
// Handshake: a beat transfers from requester i in any cycle where
// req_valid[i] && req_ready[i]. req_ready is a combinational one-hot grant
// that is only ever set for a requester that is already valid. It is never
// set outside RUN, while flush_req is high, or while rst_n is low. Responses
// (rsp_valid/rsp_data) cannot be backpressured.
module ring_path_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int PIPE_LAT  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dp_valid,
  output logic [DATA_W-1:0]         dp_data_in,
  input  logic [DATA_W-1:0]         dp_data_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      busy,
  output logic [1:0]                fsm_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(PIPE_LAT + 2);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   owner;
  logic [BW-1:0]    burst_cnt;
  logic             grant_hit, grant_fast;
  logic [IDW-1:0]   grant_id;
  logic [CW-1:0]    inflight, inflight_nxt;
  logic             tag_v  [PIPE_LAT+1];
  logic [IDW-1:0]   tag_id [PIPE_LAT+1];
  logic             rsp_fire;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: a flush stops grants immediately, waits for the path to empty, then holds
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (flush_req)          state_nxt = DRAIN;
      DRAIN:   if (inflight == '0)     state_nxt = HALT;
      HALT:    if (!flush_req)         state_nxt = RUN;
      default:                         state_nxt = RUN;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    flush_done = (state == HALT);
    fsm_state  = state;
  end

  // Arbiter: keep the owner until its burst cap is reached, otherwise scan owner+1 .. owner
  always_comb begin
    grant_fast = 1'b0;
    grant_hit  = 1'b0;
    grant_id   = owner;
    if (rst_n && state == RUN && !flush_req) begin
      if (req_valid[owner] && burst_cnt < BW'(MAX_BURST)) begin
        grant_fast = 1'b1;
        grant_hit  = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!grant_hit && req_valid[(int'(owner) + k) % NUM_REQ]) begin
            grant_hit = 1'b1;
            grant_id  = IDW'((int'(owner) + k) % NUM_REQ);
          end
        end
      end
    end
  end

  // One-hot grant from the arbiter result
  always_comb begin
    req_ready = '0;
    if (grant_hit) req_ready[grant_id] = 1'b1;
  end

  // Owner/burst bookkeeping. A regrant through the scan (sole requester) restarts the burst at 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= '0;
      burst_cnt <= '0;
    end else if (grant_hit) begin
      if (grant_fast) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        owner     <= grant_id;
        burst_cnt <= BW'(1);
      end
    end else begin
      burst_cnt <= '0;
    end
  end

  // Launch register plus the ID tag pipeline. Stage 0 is aligned with dp_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_data_in <= '0;
      for (int k = 0; k <= PIPE_LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      dp_data_in <= grant_hit ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
      tag_v[0]   <= grant_hit;
      tag_id[0]  <= grant_id;
      for (int k = 1; k <= PIPE_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign dp_valid = tag_v[0];
  assign rsp_fire = tag_v[PIPE_LAT];

  // Response routing straight from the tail of the tag pipeline
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rsp_fire) begin
      rsp_valid[tag_id[PIPE_LAT]] = 1'b1;
      rsp_data                    = dp_data_out;
    end
  end

  // In-flight count: accept adds one, response removes one
  always_comb begin
    inflight_nxt = inflight;
    if (grant_hit && !rsp_fire)      inflight_nxt = inflight + 1'b1;
    else if (!grant_hit && rsp_fire) inflight_nxt = inflight - 1'b1;
  end

  // In-flight register; busy tracks the updated count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
      busy     <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      busy     <= (inflight_nxt != '0);
    end
  end

endmodule

// File: tb/tb_ring_path_arbiter.sv
// Bench for ring_path_arbiter. The main instance uses MAX_BURST=4 and a
// second instance uses MAX_BURST=1 for the round-robin order. The shared
// datapath is a 2-cycle identity pipe. Each accepted beat pushes
// {due_cycle, one-hot id, data} into an expected queue, and a negedge monitor
// pops and compares the entry in the cycle it falls due.
module tb_ring_path_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int PL = 2;
  localparam int EW = 32 + NR + DW;

  // Clock/reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] rr_q[$];

  // Main instance signals
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             flush_req = 1'b0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic             dp_valid, flush_done, busy;
  logic [DW-1:0]    dp_data_in, dp_data_out, rsp_data;
  logic [1:0]       fsm_state;
  logic [DW-1:0]    d1, d2;

  // Round-robin instance signals
  logic [NR-1:0]    rr_valid = '0;
  logic [NR*DW-1:0] rr_data = '0;
  logic             rr_flush = 1'b0;
  logic [NR-1:0]    rr_ready, rr_rsp_valid;
  logic             rr_dp_valid, rr_flush_done, rr_busy;
  logic [DW-1:0]    rr_dp_in, rr_dp_out, rr_rsp_data;
  logic [1:0]       rr_state;
  logic [DW-1:0]    r1, r2;

  ring_path_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(PL), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_valid(dp_valid), .dp_data_in(dp_data_in),
    .dp_data_out(dp_data_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy), .fsm_state(fsm_state)
  );

  ring_path_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(PL), .MAX_BURST(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(rr_valid), .req_data(rr_data),
    .req_ready(rr_ready), .dp_valid(rr_dp_valid), .dp_data_in(rr_dp_in),
    .dp_data_out(rr_dp_out), .rsp_valid(rr_rsp_valid), .rsp_data(rr_rsp_data),
    .flush_req(rr_flush), .flush_done(rr_flush_done), .busy(rr_busy), .fsm_state(rr_state)
  );

  // Two-cycle identity datapath models
  always @(posedge clk) begin
    d1 <= dp_data_in; d2 <= d1;
    r1 <= rr_dp_in;   r2 <= r1;
  end
  assign dp_data_out = d2;
  assign rr_dp_out   = r2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitors: compare the due entry, otherwise require silence
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0][EW-1:NR+DW] == cyc) begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e[NR+DW-1:DW]));
        chk("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (rr_q.size() > 0 && rr_q[0][EW-1:NR+DW] == cyc) begin
        e = rr_q.pop_front();
        chk("rr_rsp_valid", 32'(rr_rsp_valid), 32'(e[NR+DW-1:DW]));
        chk("rr_rsp_data", 32'(rr_rsp_data), 32'(e[DW-1:0]));
      end else begin
        chk("rr_rsp_idle", 32'(rr_rsp_valid), 32'd0);
      end
    end
  end

  // Driver tasks
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [NR-1:0] v);
    req_valid = v;
    req_data  = {8'($urandom_range(255)), 8'($urandom_range(255)),
                 8'($urandom_range(255)), 8'($urandom_range(255))};
  endtask

  // Sample at negedge, check the expected grant and record the expected response
  task automatic step(input string tag, input logic [NR-1:0] g, input bit rr);
    logic [DW-1:0] d;
    @(negedge clk);
    d = '0;
    for (int i = 0; i < NR; i++)
      if (g[i]) d = rr ? rr_data[i*DW +: DW] : req_data[i*DW +: DW];
    if (rr) begin
      chk(tag, 32'(rr_ready), 32'(g));
      if (g != '0) rr_q.push_back({32'(cyc + 1 + PL), g, d});
    end else begin
      chk(tag, 32'(req_ready), 32'(g));
      if (g != '0) exp_q.push_back({32'(cyc + 1 + PL), g, d});
    end
  endtask

  task automatic idle(input int n);
    drive('0);
    for (int i = 0; i < n; i++) begin
      step("idle_grant", '0, 0);
      next();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_dpv"}, 32'(dp_valid), 0);
    chk({tag, "_dpin"}, 32'(dp_data_in), 0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 0);
    chk({tag, "_rspd"}, 32'(rsp_data), 0);
    chk({tag, "_done"}, 32'(flush_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  localparam logic [NR-1:0] BURST_G [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};

  initial begin
    // Reset
    drive('0);
    req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single beat from requester 2, tag and timing
    drive(4'b0100);
    req_data[2*DW +: DW] = 8'hA5;
    step("t1_grant", 4'b0100, 0);
    next();
    drive('0);
    step("t1_idle", '0, 0);
    chk("t1_dpv", 32'(dp_valid), 1);
    chk("t1_dpin", 32'(dp_data_in), 32'hA5);
    chk("t1_busy1", 32'(busy), 1);
    next(); step("t1_idle", '0, 0); chk("t1_busy2", 32'(busy), 1);
    next(); step("t1_idle", '0, 0); chk("t1_busy3", 32'(busy), 1);
    next(); step("t1_idle", '0, 0); chk("t1_busy4", 32'(busy), 0);
    next();

    // Burst cap: two contenders, then a sole requester
    for (int i = 0; i < 9; i++) begin
      drive(4'b0011);
      step("burst_grant", BURST_G[i], 0);
      next();
    end
    for (int i = 0; i < 6; i++) begin
      drive(4'b0001);
      step("sole_grant", 4'b0001, 0);
      next();
    end
    idle(4);

    // Flush with two beats in flight
    drive(4'b0010); step("fl_pre", 4'b0010, 0); next();
    drive(4'b0010); step("fl_pre", 4'b0010, 0); next();
    flush_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("fl_block", '0, 0);
      chk("fl_done_lo", 32'(flush_done), 0);
      next();
    end
    step("fl_block", '0, 0);
    chk("fl_done_hi", 32'(flush_done), 1);
    next();
    flush_req = 1'b0;
    step("fl_halt", '0, 0);
    chk("fl_done_hold", 32'(flush_done), 1);
    next();
    step("fl_resume", 4'b0010, 0);
    chk("fl_done_clr", 32'(flush_done), 0);
    next();

    // Reset with beats in flight
    drive(4'b1000); step("rst_pre", 4'b1000, 0); next();
    rst_n = 1'b0;
    exp_q.delete();
    drive(4'b1100);
    @(negedge clk);
    chk("rst_ready_low", 32'(req_ready), 0);
    next();
    @(negedge clk);
    chk_all_zero("rst_mid");
    next();
    rst_n = 1'b1;
    step("rst_first", 4'b0100, 0);
    next();

    // Back-to-back saturation from rotating requesters
    for (int k = 0; k < 16; k++) begin
      req_valid = 4'b0001 << (k % NR);
      req_data  = {NR{8'(k)}};
      step("sat_grant", 4'b0001 << (k % NR), 0);
      chk("sat_inflight", 32'(dut.inflight <= 2'(PL + 1)), 1);
      next();
    end
    idle(5);

    // Round-robin order with MAX_BURST=1
    for (int k = 0; k < 8; k++) begin
      rr_valid = 4'b1111;
      rr_data  = {8'($urandom_range(255)), 8'($urandom_range(255)),
                  8'($urandom_range(255)), 8'($urandom_range(255))};
      step("rr_grant", 4'b0001 << (k % NR), 1);
      next();
    end
    rr_valid = '0;
    repeat (5) next();

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("rr_q_empty", 32'(rr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
